// File: rtl/fft_bar_builder_pkg.sv
// Shared constants, FSM states and the scale/saturate helper for the FFT bar builder.
// The optional peak-hold build is selected with the BAR_PEAK_HOLD_EN macro.
package fft_bar_builder_pkg;

  localparam int FFT_LEN     = 1024;
  localparam int BAR_NUM     = 32;
  localparam int DATA_W      = 16;
  localparam int HEIGHT_W    = 8;
  localparam int SCALE_SHIFT = 6;
  localparam int DECAY       = 1;

  localparam int HALF      = FFT_LEN / 2;
  localparam int BINS      = HALF / BAR_NUM;
  localparam int BAR_AW    = $clog2(BAR_NUM);
  localparam int HMAX      = (1 << HEIGHT_W) - 1;
  localparam int CNT_W     = $clog2(FFT_LEN);
  localparam int BIN_SHIFT = $clog2(BINS);

  typedef enum logic [1:0] {IDLE, ACCUM, SKIP, COMMIT} state_e;

  function automatic logic [HEIGHT_W-1:0] satShift(input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] shifted;
    shifted = value >> SCALE_SHIFT;
    if (shifted > DATA_W'(HMAX)) return HEIGHT_W'(HMAX);
    return shifted[HEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/fft_bar_builder_if.sv
// Amplitude stream and LCD read port of the FFT bar builder.
// Widths are shared through fft_bar_builder_pkg (BAR_PEAK_HOLD_EN does not affect this file).
interface fft_bar_builder_if;
  import fft_bar_builder_pkg::*;

  logic [DATA_W-1:0]   fft_data;
  logic                fft_sop;
  logic                fft_eop;
  logic                fft_valid;
  logic [BAR_AW-1:0]   rd_addr;
  logic [HEIGHT_W-1:0] rd_data;
  logic                frame_done;
  logic                frame_err;

  modport master (
    output fft_data, fft_sop, fft_eop, fft_valid, rd_addr,
    input  rd_data, frame_done, frame_err
  );

  modport slave (
    input  fft_data, fft_sop, fft_eop, fft_valid, rd_addr,
    output rd_data, frame_done, frame_err
  );
endinterface

// File: rtl/fft_bar_builder_bar_bank_2x.sv
// Double-buffered bar height array: writes land in the back bank, readers see the front bank.
// With BAR_PEAK_HOLD_EN a second, combinational front-bank read port feeds the peak-hold logic.
module bar_bank_2x
  import fft_bar_builder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [BAR_AW-1:0]   waddr_i,
  input  logic [HEIGHT_W-1:0] wdata_i,
  input  logic                swap_i,
  input  logic [BAR_AW-1:0]   rdAddr_i,
  output logic [HEIGHT_W-1:0] rdData_o
`ifdef BAR_PEAK_HOLD_EN
  ,
  input  logic [BAR_AW-1:0]   phAddr_i,
  output logic [HEIGHT_W-1:0] phData_o
`endif
);

  logic [HEIGHT_W-1:0] bank_q [2][BAR_NUM];
  logic                bankSel_q;
  logic [HEIGHT_W-1:0] rdData_q;

  // The LCD read uses the pre-swap select, so a read in the swap cycle still returns the old frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BAR_NUM; i++) begin
        bank_q[0][i] <= '0;
        bank_q[1][i] <= '0;
      end
      bankSel_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      if (we_i) bank_q[~bankSel_q][waddr_i] <= wdata_i;
      if (swap_i) bankSel_q <= ~bankSel_q;
      rdData_q <= bank_q[bankSel_q][rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

`ifdef BAR_PEAK_HOLD_EN
  assign phData_o = bank_q[bankSel_q][phAddr_i];
`endif

endmodule

// File: rtl/fft_bar_builder.sv
// Reduces the positive half of each FFT amplitude frame to BAR_NUM saturated bar heights.
// Define BAR_PEAK_HOLD_EN to make bars fall by at most DECAY per committed frame.
module fft_bar_builder
  import fft_bar_builder_pkg::*;
(
  input logic              clk,
  input logic              rst,
  fft_bar_builder_if.slave bus
);

  localparam logic [CNT_W-1:0] BIN_MASK  = CNT_W'(BINS - 1);
  localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    binCnt_q;
  logic [DATA_W-1:0]   curMax_q;
  logic                frameDone_q;
  logic                frameErr_q;

  logic [CNT_W-1:0]    sampleIdx;
  logic [DATA_W-1:0]   newMax_d;
  logic                takeSample;
  logic                barWe;
  logic [BAR_AW-1:0]   barIdx;
  logic [HEIGHT_W-1:0] scaled;
  logic [HEIGHT_W-1:0] barData_d;
`ifdef BAR_PEAK_HOLD_EN
  logic [HEIGHT_W-1:0] frontBar;
  logic [HEIGHT_W-1:0] decayed;
`endif

  // A sop sample always counts as bin 0, which also covers the restart-on-sop error path.
  always_comb begin
    sampleIdx  = bus.fft_sop ? '0 : binCnt_q;
    takeSample = bus.fft_valid && !bus.fft_eop && (state_q != COMMIT) &&
                 (bus.fft_sop || (state_q == ACCUM));
    if (((sampleIdx & BIN_MASK) == '0) || (bus.fft_data > curMax_q)) newMax_d = bus.fft_data;
    else newMax_d = curMax_q;
    barWe  = takeSample && ((sampleIdx & BIN_MASK) == BIN_MASK);
    barIdx = BAR_AW'(sampleIdx >> BIN_SHIFT);
    scaled = satShift(newMax_d);
`ifdef BAR_PEAK_HOLD_EN
    decayed   = (frontBar > HEIGHT_W'(DECAY)) ? frontBar - HEIGHT_W'(DECAY) : '0;
    barData_d = (scaled > decayed) ? scaled : decayed;
`else
    barData_d = scaled;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      binCnt_q    <= '0;
      curMax_q    <= '0;
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
      if (takeSample) curMax_q <= newMax_d;
      case (state_q)
        IDLE: begin
          if (bus.fft_valid && bus.fft_sop) begin
            if (bus.fft_eop) frameErr_q <= 1'b1;
            else begin
              binCnt_q <= CNT_W'(1);
              state_q  <= ACCUM;
            end
          end
        end
        ACCUM, SKIP: begin
          if (bus.fft_valid) begin
            if (bus.fft_sop) begin
              frameErr_q <= 1'b1;
              if (bus.fft_eop) begin
                binCnt_q <= '0;
                state_q  <= IDLE;
              end else begin
                binCnt_q <= CNT_W'(1);
                state_q  <= ACCUM;
              end
            end else if (bus.fft_eop) begin
              binCnt_q <= '0;
              if ((state_q == SKIP) && (binCnt_q == LAST_BIN)) begin
                frameDone_q <= 1'b1;
                state_q     <= COMMIT;
              end else begin
                frameErr_q <= 1'b1;
                state_q    <= IDLE;
              end
            end else if (binCnt_q == LAST_BIN) begin
              frameErr_q <= 1'b1;
              binCnt_q   <= '0;
              state_q    <= IDLE;
            end else begin
              binCnt_q <= binCnt_q + CNT_W'(1);
              if ((state_q == ACCUM) && (binCnt_q == HALF_LAST)) state_q <= SKIP;
            end
          end
        end
        COMMIT: begin
          binCnt_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bar_bank_2x u_bank (
    .clk      (clk),
    .rst      (rst),
    .we_i     (barWe),
    .waddr_i  (barIdx),
    .wdata_i  (barData_d),
    .swap_i   (state_q == COMMIT),
    .rdAddr_i (bus.rd_addr),
    .rdData_o (bus.rd_data)
`ifdef BAR_PEAK_HOLD_EN
    ,
    .phAddr_i (barIdx),
    .phData_o (frontBar)
`endif
  );

  assign bus.frame_done = frameDone_q;
  assign bus.frame_err  = frameErr_q;

endmodule

// File: tb/tb_fft_bar_builder.sv
// Directed self-checking bench for fft_bar_builder; expected bar heights come from hand formulas.
// Follows BAR_PEAK_HOLD_EN so the same bench covers both builds.
module tb_fft_bar_builder;
  import fft_bar_builder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int doneCount = 0;
  int errCount  = 0;
  int tbFront [BAR_NUM];

  always #10 clk = ~clk;

  fft_bar_builder_if bus ();

  fft_bar_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Pulse counters sample pre-edge values at each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.frame_done === 1'b1) doneCount++;
      if (bus.frame_err === 1'b1) errCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int ampFor(input int pattern, input int k);
    case (pattern)
      0: return (k < 512) ? k * 64 : 0;
      1: return 255 * 64;
      2: return 0;
      3: return (k < 512) ? k * 32 : 0;
      4: return 200 * 64;
      5: return 5 * 64;
      default: return 100 * 64;
    endcase
  endfunction

  // Hand-derived bar heights for each pattern (before peak hold).
  function automatic int scaledFor(input int pattern, input int b);
    case (pattern)
      0: return (b < 16) ? b * 16 + 15 : 255;
      1: return 255;
      2: return 0;
      3: return b * 8 + 7;
      4: return 200;
      5: return 5;
      default: return 100;
    endcase
  endfunction

  function automatic int holdBar(input int s, input int prev);
`ifdef BAR_PEAK_HOLD_EN
    int d;
    d = (prev > 1) ? prev - 1 : 0;
    return (s > d) ? s : d;
`else
    return s;
`endif
  endfunction

  task automatic commitModel(input int pattern);
    for (int b = 0; b < BAR_NUM; b++) tbFront[b] = holdBar(scaledFor(pattern, b), tbFront[b]);
  endtask

  task automatic applyStimulus(input int pattern, input int length, input int eopAt);
    for (int k = 0; k < length; k++) begin
      @(negedge clk);
      bus.fft_valid = 1'b1;
      bus.fft_sop   = (k == 0);
      bus.fft_eop   = (k == eopAt);
      bus.fft_data  = 16'(ampFor(pattern, k));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.fft_valid = 1'b0;
      bus.fft_sop   = 1'b0;
      bus.fft_eop   = 1'b0;
      bus.fft_data  = '0;
    end
  endtask

  task automatic verifyBars(input string tag);
    for (int b = 0; b < BAR_NUM; b++) begin
      @(negedge clk);
      bus.rd_addr = BAR_AW'(b);
      @(negedge clk);
      checkOutput($sformatf("%s_bar%0d", tag, b), 32'(bus.rd_data), 32'(tbFront[b]));
    end
  endtask

  initial begin
    int d0, e0, oldBar;
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    bus.fft_eop   = 1'b0;
    bus.fft_data  = '0;
    bus.rd_addr   = '0;
    for (int b = 0; b < BAR_NUM; b++) tbFront[b] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 0);
    checkOutput("reset_frame_done", 32'(bus.frame_done), 0);
    checkOutput("reset_frame_err", 32'(bus.frame_err), 0);
    rst = 1'b0;
    verifyBars("reset");

    // Ramp frame: low bars follow the ramp, upper bars saturate.
    d0 = doneCount; e0 = errCount;
    applyStimulus(0, 1024, 1023);
    idleCycles(3);
    commitModel(0);
    checkOutput("ramp_done", 32'(doneCount - d0), 1);
    checkOutput("ramp_err", 32'(errCount - e0), 0);
    verifyBars("ramp");

    // Full-scale frame followed by a silent one shows the peak-hold decay.
    applyStimulus(1, 1024, 1023);
    idleCycles(3);
    commitModel(1);
    verifyBars("full");
    applyStimulus(2, 1024, 1023);
    idleCycles(3);
    commitModel(2);
    verifyBars("zero");

    // Early eop is discarded and leaves the front bank untouched.
    d0 = doneCount; e0 = errCount;
    applyStimulus(5, 701, 700);
    idleCycles(3);
    checkOutput("early_eop_err", 32'(errCount - e0), 1);
    checkOutput("early_eop_done", 32'(doneCount - d0), 0);
    verifyBars("early_eop");

    // A second sop at bin 300 restarts the frame on that sample.
    d0 = doneCount; e0 = errCount;
    applyStimulus(6, 300, -1);
    applyStimulus(3, 1024, 1023);
    idleCycles(3);
    commitModel(3);
    checkOutput("restart_err", 32'(errCount - e0), 1);
    checkOutput("restart_done", 32'(doneCount - d0), 1);
    verifyBars("restart");

    // Read of bar 5 across the commit cycle.
    oldBar = tbFront[5];
    @(negedge clk);
    bus.rd_addr = BAR_AW'(5);
    applyStimulus(4, 1024, 1023);
    idleCycles(1);
    checkOutput("commit_cycle_done", 32'(bus.frame_done), 1);
    @(negedge clk);
    checkOutput("commit_read_old", 32'(bus.rd_data), 32'(oldBar));
    commitModel(4);
    @(negedge clk);
    checkOutput("commit_read_new", 32'(bus.rd_data), 32'(tbFront[5]));
    idleCycles(2);

    // Reset in the middle of a frame discards it and clears both banks.
    applyStimulus(1, 200, -1);
    @(negedge clk);
    rst = 1'b1;
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    #1;
    checkOutput("midreset_rd_data", 32'(bus.rd_data), 0);
    checkOutput("midreset_frame_done", 32'(bus.frame_done), 0);
    checkOutput("midreset_frame_err", 32'(bus.frame_err), 0);
    for (int b = 0; b < BAR_NUM; b++) tbFront[b] = 0;
    @(negedge clk);
    rst = 1'b0;
    verifyBars("midreset");
    d0 = doneCount; e0 = errCount;
    applyStimulus(3, 1024, 1023);
    idleCycles(3);
    commitModel(3);
    checkOutput("post_reset_done", 32'(doneCount - d0), 1);
    checkOutput("post_reset_err", 32'(errCount - e0), 0);
    verifyBars("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
